// File: rtl/uart_rx_core.sv
// 8N1 asynchronous serial receiver with a run-time clock divider and a valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd / parity_err) between data and stop.
module uart_rx_core #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned MIN_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             rxd,
`ifdef UART_RX_PARITY_EN
  input  logic             parity_odd,
  output logic             parity_err,
`endif
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StStop, StBrk
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e           state_q, state_d;
  logic             rxd_meta_q, rxd_s_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             load;
  logic [DIV_W-1:0] div_eff, div_m1, half_m1;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign div_m1  = div_eff - 1'b1;
  assign half_m1 = (div_eff >> 1) - 1'b1;

  // >= rather than == so a mid-frame shrink of cfg_div cannot stall a counter past its compare.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    load        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q >= half_m1) begin
          cnt_d    = '0;
          bitidx_d = '0;
          state_d  = rxd_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StData: begin
        if (cnt_q >= div_m1) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q >= div_m1) begin
          cnt_d   = '0;
          state_d = StStop;
          if (rxd_s_q != ((^shift_q) ^ parity_odd)) begin
            par_bad_d    = 1'b1;
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (cnt_q >= div_m1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            load = ~par_bad_q;
`else
            load = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBrk;
          end
        end
      end
      StBrk: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A load wins over a same-cycle read; a new overrun wins over overrun_clr.
  always_comb begin
    rx_data_d  = load ? shift_q : rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (load) rx_valid_d = 1'b1;
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (load && rx_valid_q && !rx_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Chip-side serial receiver for the rs232_dce_rxd line driven by the host/bench: 8N1 asynchronous frames in, bytes out over a valid/ready holding register.
- Sits between the pad and the CPU-facing UART register block.
- Complements the existing transmit path on rs232_dce_txd.
- Baud set at run time by a clock divider.

Parameters:
- DIV_W, 16, width of cfg_div (clocks per bit).
- MIN_DIV, 4, smallest divider honoured. Smaller cfg_div values are treated as MIN_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_async  input  1  asynchronous, active-low reset (0 = reset).
- cfg_div  input  DIV_W  clocks per bit, sampled continuously.
- rxd  input  1  raw serial line, asynchronous to clk, idle high.
- rx_data  output  8  received byte, LSB first on the wire.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while rx_valid was already 1.
- overrun_clr  input  1  clears overrun.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_async low, async assert, sync-to-clk release):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops = 1; state=IDLE; counters=0.
- Input sync: two flops; rxd_s = rxd delayed 2 clocks. All decisions use rxd_s only.
- Divider: D = max(cfg_div, MIN_DIV). Half = D>>1. Bit counter cnt is DIV_W wide and reset to 0 on every state change.
- States:
  - IDLE: on rxd_s==0 -> START, cnt=0.
  - START: cnt increments. At cnt==Half-1 sample rxd_s:
    - 0 -> DATA, cnt=0, bitidx=0.
    - 1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt==D-1 shift rxd_s into shift reg MSB (LSB-first reconstruction) and set cnt=0. After bitidx==7 -> STOP (or PARITY when feature enabled); else bitidx+1.
  - STOP: at cnt==D-1 sample rxd_s:
    - 1 -> load rx_data, set rx_valid, -> IDLE.
    - 0 -> frame_err=1 for one cycle, byte discarded -> BRK.
  - BRK: wait for rxd_s==1, then -> IDLE. No new start is detected while in BRK.
- Handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready.
  - rx_data stable while rx_valid=1 unless overrun occurs.
- Boundary cases:
  - Byte completes while rx_valid=1 and rx_ready=0: rx_data overwritten, rx_valid stays 1, overrun=1.
  - Byte completes in the same cycle as an accepting read: new byte loaded, rx_valid stays 1, no overrun.
  - overrun_clr and a new overrun in the same cycle: overrun stays 1.
- cfg_div change mid-frame takes effect on the next cnt compare. The in-flight frame is not guaranteed.
- Latency: rx_valid rises 2 (sync) + Half + 9*D clocks after the start-bit falling edge on rxd, +/-1.
- Reset mid-frame: immediate return to reset values; the partial byte is lost.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: adds input parity_odd (1 = odd, 0 = even) and a PARITY state between DATA and STOP. Parity is sampled at cnt==D-1.
  - Mismatch: parity_err pulses 1 cycle, byte discarded, FSM still proceeds through STOP.
  - Frame becomes 11 bits; latency +D.
- Not defined: no parity_odd/parity_err ports, no PARITY state, 8N1 only.

Test Plan:
- Reset: hold reset_async=0 for 555 ns with rxd toggling -> all outputs 0 and busy=0 throughout. After release, with rxd=1, state remains IDLE.
- Basic byte: cfg_div=16, send 0xA5 (8N1) -> rx_data=0xA5, rx_valid=1 at 2+8+144 clocks after the start edge (+/-1). rx_ready=1 for one cycle -> rx_valid=0 next cycle.
- Glitch: rxd low for 3 clocks with cfg_div=16 -> no busy beyond START, rx_valid stays 0, frame_err never pulses.
- Framing: send 0x3C with stop bit 0, then hold line low for 40 clocks, then high -> frame_err one-cycle pulse, rx_valid=0. A following 0x55 is received correctly.
- Overrun: send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, overrun=1. Pulse overrun_clr -> overrun=0, rx_valid still 1.
- Min divider: cfg_div=1, send 0x80 at 4 clocks/bit -> rx_data=0x80. With UART_RX_PARITY_EN, parity_odd=0, even parity, send 0x07 with a wrong parity bit -> parity_err pulse, rx_valid=0.
